// File: rtl/mem_result_checker.sv
// -----------------------------------------------------------------------------
// mem_result_checker
//
// End-of-program checker for a pipelined CPU bench and the FPGA bring-up
// harness. It watches the fetched instruction stream for a run of NOPs that
// marks program halt. After halt, or when force_check is pulsed, it sweeps
// NUM_WORDS words of the DUT data memory. Each word is compared with an
// expected-result memory through two read ports that share one strobe and one
// address and return data one cycle after the strobe.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous reset, active-high
//   inst           instruction currently presented by instruction memory
//   inst_valid     qualifies inst
//   force_check    single-cycle pulse; starts the sweep without halt detection
//   rd_en          read strobe shared by both memories
//   rd_addr        byte address shared by both memories
//   dut_rdata      DUT memory read data (1 cycle after rd_en)
//   exp_rdata      expected memory read data (1 cycle after rd_en)
//   cmp_valid      per-word compare result valid this cycle
//   cmp_idx        index of the reported word
//   cmp_match      reported word matched
//   pass_count     number of matching words so far
//   fail_count     number of mismatching words so far
//   first_fail_idx lowest failing index (0 if none)
//   any_fail       at least one word has failed
//   halted         halt was detected from the instruction stream
//   done           sweep complete; sticky until rst
// -----------------------------------------------------------------------------
module mem_result_checker #(
    parameter int                    WORD_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    NUM_WORDS  = 100,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    HALT_COUNT = 10,
    parameter logic [WORD_WIDTH-1:0] NOP_WORD   = '0,
    parameter int                    HALT_MODE  = 1,
    localparam int                   CW         = $clog2(NUM_WORDS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] inst,
    input  logic                  inst_valid,
    input  logic                  force_check,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [WORD_WIDTH-1:0] dut_rdata,
    input  logic [WORD_WIDTH-1:0] exp_rdata,
    output logic                  cmp_valid,
    output logic [CW-1:0]         cmp_idx,
    output logic                  cmp_match,
    output logic [CW-1:0]         pass_count,
    output logic [CW-1:0]         fail_count,
    output logic [CW-1:0]         first_fail_idx,
    output logic                  any_fail,
    output logic                  halted,
    output logic                  done
);

    localparam int              HCW        = $clog2(HALT_COUNT + 1);
    localparam logic [HCW-1:0]  HALT_LIMIT = HCW'(HALT_COUNT);
    localparam logic [CW-1:0]   LAST_IDX   = CW'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        WATCH = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Control state
    // -------------------------------------------------------------------------
    state_t          state_reg;
    state_t          state_next;
    logic [HCW-1:0]  halt_cnt_reg;
    logic [HCW-1:0]  halt_cnt_next;
    logic            halted_reg;
    logic            halted_next;
    logic            issue_go;

    // -------------------------------------------------------------------------
    // Issue stage: address generator and registered read strobe
    // -------------------------------------------------------------------------
    logic [CW-1:0]          issue_cnt_reg;
    logic [ADDR_WIDTH-1:0]  addr_ptr_reg;
    logic                   rd_en_reg;
    logic [ADDR_WIDTH-1:0]  rd_addr_reg;
    logic [CW-1:0]          rd_idx_reg;

    // -------------------------------------------------------------------------
    // Compare stage
    // -------------------------------------------------------------------------
    logic                   pend_valid_reg;
    logic [CW-1:0]          pend_idx_reg;
    logic                   cmp_valid_reg;
    logic [CW-1:0]          cmp_idx_reg;
    logic                   cmp_match_reg;
    logic [CW-1:0]          pass_count_reg;
    logic [CW-1:0]          fail_count_reg;
    logic [CW-1:0]          first_fail_reg;
    logic                   any_fail_reg;

    logic [WORD_WIDTH-1:0]  bit_eq;
    logic                   word_match;

    // Per-bit equality. Reducing it inside an if() makes any unknown bit on
    // the read data fall through to the mismatch branch in simulation.
    generate
        for (genvar gi = 0; gi < WORD_WIDTH; gi++) begin : g_bit_eq
            assign bit_eq[gi] = ~(dut_rdata[gi] ^ exp_rdata[gi]);
        end
    endgenerate

    always_comb begin
        word_match = 1'b0;
        if (&bit_eq) begin
            word_match = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state and halt detection
    // -------------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        halt_cnt_next = halt_cnt_reg;
        halted_next   = halted_reg;
        issue_go      = 1'b0;

        case (state_reg)
            WATCH: begin
                if (inst_valid) begin
                    if (inst == NOP_WORD) begin
                        if (halt_cnt_reg != HALT_LIMIT) begin
                            halt_cnt_next = halt_cnt_reg + HCW'(1);
                        end
                    end else if (HALT_MODE == 1) begin
                        // Consecutive mode: any real instruction breaks the run.
                        halt_cnt_next = '0;
                    end
                end

                // Halt wins over force_check so halted is still reported
                // when both happen in the same cycle.
                if (halt_cnt_next == HALT_LIMIT) begin
                    halted_next = 1'b1;
                    state_next  = SWEEP;
                end else if (force_check) begin
                    state_next  = SWEEP;
                end
            end

            SWEEP: begin
                issue_go = 1'b1;
                if (issue_cnt_reg == LAST_IDX) begin
                    state_next = DRAIN;
                end
            end

            DRAIN: begin
                // Reads are in order, so the last index registered means
                // every word has been compared.
                if (cmp_valid_reg && (cmp_idx_reg == LAST_IDX)) begin
                    state_next = DONE;
                end
            end

            DONE: begin
                state_next = DONE;
            end

            default: begin
                state_next = WATCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= WATCH;
            halt_cnt_reg <= '0;
            halted_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            halt_cnt_reg <= halt_cnt_next;
            halted_reg   <= halted_next;
        end
    end

    // -------------------------------------------------------------------------
    // Issue stage. The strobe is registered, so the first rd_en appears one
    // cycle after the FSM enters SWEEP. The last strobe is therefore still
    // high during the first DRAIN cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt_reg <= '0;
            addr_ptr_reg  <= BASE_ADDR;
            rd_en_reg     <= 1'b0;
            rd_addr_reg   <= '0;
            rd_idx_reg    <= '0;
        end else begin
            rd_en_reg <= issue_go;
            if (issue_go) begin
                rd_addr_reg   <= addr_ptr_reg;
                rd_idx_reg    <= issue_cnt_reg;
                // Natural modulo-2^ADDR_WIDTH wrap.
                addr_ptr_reg  <= addr_ptr_reg + ADDR_WIDTH'(4);
                issue_cnt_reg <= issue_cnt_reg + CW'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Compare stage. pend_* marks the cycle in which the memories present
    // data for an earlier strobe. The compare result and the counters are
    // registered on the same edge, so pass_count + fail_count always equals
    // the number of words reported.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid_reg <= 1'b0;
            pend_idx_reg   <= '0;
            cmp_valid_reg  <= 1'b0;
            cmp_idx_reg    <= '0;
            cmp_match_reg  <= 1'b0;
            pass_count_reg <= '0;
            fail_count_reg <= '0;
            first_fail_reg <= '0;
            any_fail_reg   <= 1'b0;
        end else begin
            pend_valid_reg <= rd_en_reg;
            pend_idx_reg   <= rd_idx_reg;
            cmp_valid_reg  <= pend_valid_reg;

            if (pend_valid_reg) begin
                cmp_idx_reg   <= pend_idx_reg;
                cmp_match_reg <= word_match;
                if (word_match) begin
                    pass_count_reg <= pass_count_reg + CW'(1);
                end else begin
                    fail_count_reg <= fail_count_reg + CW'(1);
                    if (!any_fail_reg) begin
                        any_fail_reg   <= 1'b1;
                        first_fail_reg <= pend_idx_reg;
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign rd_en          = rd_en_reg;
    assign rd_addr        = rd_addr_reg;
    assign cmp_valid      = cmp_valid_reg;
    assign cmp_idx        = cmp_idx_reg;
    assign cmp_match      = cmp_match_reg;
    assign pass_count     = pass_count_reg;
    assign fail_count     = fail_count_reg;
    assign first_fail_idx = first_fail_reg;
    assign any_fail       = any_fail_reg;
    assign halted         = halted_reg;
    assign done           = (state_reg == DONE);

endmodule

// File: tb/tb_mem_result_checker.sv
// -----------------------------------------------------------------------------
// Testbench for mem_result_checker.
// Instance A uses the default configuration: consecutive halt counting,
// 100 words, and base address 0.
// Instance B uses 8-bit addresses with base 0xF8, 4 words, and cumulative
// halt counting. It exercises address wraparound, cumulative NOP counting
// and force_check.
// Only one instance is active at a time; the other is held in reset.
// A scoreboard queue gets the expected compare for each read issue. Entries
// are popped and checked when cmp_valid appears.
// -----------------------------------------------------------------------------
module tb_mem_result_checker;

    localparam int NA = 100;
    localparam int NB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, force_a, force_b, inst_valid;
    logic [31:0] inst;

    logic        rd_en_a, cmp_valid_a, cmp_match_a, any_fail_a, halted_a, done_a;
    logic [31:0] rd_addr_a, dut_rdata_a, exp_rdata_a;
    logic [6:0]  cmp_idx_a, pass_count_a, fail_count_a, first_fail_idx_a;

    logic        rd_en_b, cmp_valid_b, cmp_match_b, any_fail_b, halted_b, done_b;
    logic [7:0]  rd_addr_b;
    logic [31:0] dut_rdata_b, exp_rdata_b;
    logic [2:0]  cmp_idx_b, pass_count_b, fail_count_b, first_fail_idx_b;

    logic [31:0] dut_mem [NA];
    logic [31:0] exp_mem [NA];

    mem_result_checker u_dut_a (
        .clk(clk), .rst(rst_a), .inst(inst), .inst_valid(inst_valid),
        .force_check(force_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
        .dut_rdata(dut_rdata_a), .exp_rdata(exp_rdata_a),
        .cmp_valid(cmp_valid_a), .cmp_idx(cmp_idx_a), .cmp_match(cmp_match_a),
        .pass_count(pass_count_a), .fail_count(fail_count_a),
        .first_fail_idx(first_fail_idx_a), .any_fail(any_fail_a),
        .halted(halted_a), .done(done_a)
    );

    mem_result_checker #(
        .WORD_WIDTH(32), .ADDR_WIDTH(8), .NUM_WORDS(NB), .BASE_ADDR(8'hF8),
        .HALT_COUNT(10), .NOP_WORD(32'h0), .HALT_MODE(0)
    ) u_dut_b (
        .clk(clk), .rst(rst_b), .inst(inst), .inst_valid(inst_valid),
        .force_check(force_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
        .dut_rdata(dut_rdata_b), .exp_rdata(exp_rdata_b),
        .cmp_valid(cmp_valid_b), .cmp_idx(cmp_idx_b), .cmp_match(cmp_match_b),
        .pass_count(pass_count_b), .fail_count(fail_count_b),
        .first_fail_idx(first_fail_idx_b), .any_fail(any_fail_b),
        .halted(halted_b), .done(done_b)
    );

    function automatic int widx_a(input logic [31:0] a);
        return int'(a[31:2]);
    endfunction

    function automatic int widx_b(input logic [7:0] a);
        logic [7:0] off;
        off = a - 8'hF8;
        return int'(off[7:2]);
    endfunction

    // Memory models with one cycle of read latency.
    always @(posedge clk) begin
        if (rd_en_a) begin
            if (widx_a(rd_addr_a) < NA) begin
                dut_rdata_a <= dut_mem[widx_a(rd_addr_a)];
                exp_rdata_a <= exp_mem[widx_a(rd_addr_a)];
            end else begin
                dut_rdata_a <= 32'h0;
                exp_rdata_a <= 32'h1;
            end
        end
        if (rd_en_b) begin
            dut_rdata_b <= dut_mem[widx_b(rd_addr_b)];
            exp_rdata_b <= exp_mem[widx_b(rd_addr_b)];
        end
    end

    // -------------------------------------------------------------------------
    // Scoreboard and check bookkeeping
    // -------------------------------------------------------------------------
    typedef struct {
        int   idx;
        logic match;
        int   cyc;
    } sb_t;

    sb_t         sb_q [$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          active, nwords, issue_k, first_rd_cyc;
    logic [31:0] base, amask;
    int          m_pass, m_fail, m_first;
    logic        m_any;

    logic        s_rd_en, s_cv, s_cm, s_any, s_halted, s_done;
    logic [31:0] s_addr, s_ci, s_pass, s_fail, s_first;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_reset();
        sb_q.delete();
        issue_k      = 0;
        first_rd_cyc = -1;
        m_pass       = 0;
        m_fail       = 0;
        m_first      = 0;
        m_any        = 1'b0;
    endtask

    task automatic sample();
        if (active == 0) begin
            s_rd_en = rd_en_a;       s_addr  = rd_addr_a;
            s_cv    = cmp_valid_a;   s_ci    = 32'(cmp_idx_a);
            s_cm    = cmp_match_a;   s_pass  = 32'(pass_count_a);
            s_fail  = 32'(fail_count_a);
            s_first = 32'(first_fail_idx_a);
            s_any   = any_fail_a;    s_halted = halted_a;   s_done = done_a;
        end else begin
            s_rd_en = rd_en_b;       s_addr  = 32'(rd_addr_b);
            s_cv    = cmp_valid_b;   s_ci    = 32'(cmp_idx_b);
            s_cm    = cmp_match_b;   s_pass  = 32'(pass_count_b);
            s_fail  = 32'(fail_count_b);
            s_first = 32'(first_fail_idx_b);
            s_any   = any_fail_b;    s_halted = halted_b;   s_done = done_b;
        end
    endtask

    task automatic monitor();
        sb_t e;
        if (s_rd_en) begin
            check("rd_en_overrun", 64'(issue_k < nwords), 64'd1);
            check("rd_addr", s_addr, (base + 32'(4 * issue_k)) & amask);
            if (issue_k == 0) first_rd_cyc = cyc;
            if (issue_k < NA) begin
                e.idx   = issue_k;
                e.match = (dut_mem[issue_k] === exp_mem[issue_k]);
                e.cyc   = cyc;
                sb_q.push_back(e);
            end
            issue_k++;
        end
        if (s_cv) begin
            if (sb_q.size() == 0) begin
                check("cmp_unexpected", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                if (e.match) begin
                    m_pass++;
                end else begin
                    m_fail++;
                    if (!m_any) begin
                        m_any   = 1'b1;
                        m_first = e.idx;
                    end
                end
                check("cmp_idx", s_ci, 64'(e.idx));
                check("cmp_match", 64'(s_cm), 64'(e.match));
                check("cmp_latency", 64'(cyc - e.cyc), 64'd2);
                check("pass_count", s_pass, 64'(m_pass));
                check("fail_count", s_fail, 64'(m_fail));
                check("any_fail", 64'(s_any), 64'(m_any));
                check("first_fail_idx", s_first, 64'(m_first));
                $display("cmp inst=%0d idx=%0d match=%0d pass=%0d fail=%0d",
                         active, s_ci, s_cm, s_pass, s_fail);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        sample();
        monitor();
    endtask

    task automatic drive_inst(input logic valid, input logic [31:0] word);
        inst_valid = valid;
        inst       = word;
        tick();
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!s_done && n < budget) begin
            tick();
            n++;
        end
        check("done_timeout", 64'(s_done), 64'd1);
    endtask

    // Hard stop in case anything stalls outside a bounded wait.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed no completion, expected summary before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_a = 1'b1; rst_b = 1'b1; force_a = 1'b0; force_b = 1'b0;
        inst_valid = 1'b0; inst = 32'h0;
        for (int i = 0; i < NA; i++) begin
            dut_mem[i] = $urandom;
            exp_mem[i] = dut_mem[i];
        end
        active = 0; nwords = NA; base = 32'h0; amask = 32'hFFFF_FFFF;
        sb_reset();

        // ---------------- A: reset state ----------------
        tick(); tick();
        check("rst_rd_en", 64'(s_rd_en), 64'd0);
        check("rst_cmp_valid", 64'(s_cv), 64'd0);
        check("rst_pass", s_pass, 64'd0);
        check("rst_fail", s_fail, 64'd0);
        check("rst_first", s_first, 64'd0);
        check("rst_any", 64'(s_any), 64'd0);
        check("rst_halted", 64'(s_halted), 64'd0);
        check("rst_done", 64'(s_done), 64'd0);
        rst_a = 1'b0;

        // ---------------- A: interrupted NOP run ----------------
        repeat (9) drive_inst(1'b1, 32'h0);
        repeat (4) drive_inst(1'b0, 32'h0);
        drive_inst(1'b1, 32'h2002_0005);
        repeat (9) drive_inst(1'b1, 32'h0);
        check("intr_halted", 64'(s_halted), 64'd0);
        check("intr_no_issue", 64'(issue_k), 64'd0);

        // ---------------- A: consecutive halt, all match ----------------
        repeat (5) drive_inst(1'b1, 32'h0085_2020);
        repeat (9) drive_inst(1'b1, 32'h0);
        check("pre_halt", 64'(s_halted), 64'd0);
        drive_inst(1'b1, 32'h0);
        check("halt_set", 64'(s_halted), 64'd1);
        check("halt_rd_en_0", 64'(s_rd_en), 64'd0);
        inst_valid = 1'b0;
        tick();
        check("first_rd_en", 64'(s_rd_en), 64'd1);
        wait_done(300);
        check("done_latency", 64'(cyc - first_rd_cyc), 64'd102);
        check("a1_pass", s_pass, 64'd100);
        check("a1_fail", s_fail, 64'd0);
        check("a1_any", 64'(s_any), 64'd0);
        check("a1_first", s_first, 64'd0);
        check("a1_issues", 64'(issue_k), 64'd100);
        check("a1_sb_empty", 64'(sb_q.size()), 64'd0);
        check("a1_done_rd_en", 64'(s_rd_en), 64'd0);
        check("a1_done_cv", 64'(s_cv), 64'd0);

        // DONE ignores force_check and further NOPs
        force_a = 1'b1;
        drive_inst(1'b1, 32'h0);
        force_a = 1'b0;
        repeat (5) drive_inst(1'b1, 32'h0);
        inst_valid = 1'b0;
        check("done_sticky", 64'(s_done), 64'd1);
        check("done_no_issue", 64'(issue_k), 64'd100);
        check("done_hold_pass", s_pass, 64'd100);

        // ---------------- A: mismatches at 7 and 42 ----------------
        rst_a = 1'b1; tick(); rst_a = 1'b0;
        check("a2_rst_done", 64'(s_done), 64'd0);
        sb_reset();
        exp_mem[7]  = exp_mem[7] ^ 32'h0000_0001;
        exp_mem[42] = exp_mem[42] ^ 32'h8000_0000;
        repeat (10) drive_inst(1'b1, 32'h0);
        inst_valid = 1'b0;
        wait_done(300);
        check("a2_pass", s_pass, 64'd98);
        check("a2_fail", s_fail, 64'd2);
        check("a2_first", s_first, 64'd7);
        check("a2_any", 64'(s_any), 64'd1);
        exp_mem[7]  = dut_mem[7];
        exp_mem[42] = dut_mem[42];

        // ---------------- A: mid-sweep reset ----------------
        rst_a = 1'b1; tick(); rst_a = 1'b0;
        sb_reset();
        repeat (10) drive_inst(1'b1, 32'h0);
        inst_valid = 1'b0;
        n = 0;
        while (issue_k < 50 && n < 200) begin
            tick();
            n++;
        end
        check("reach_50th_rd_en", 64'(issue_k), 64'd50);
        rst_a = 1'b1;
        tick();
        check("mrst_rd_en", 64'(s_rd_en), 64'd0);
        check("mrst_cv", 64'(s_cv), 64'd0);
        check("mrst_pass", s_pass, 64'd0);
        check("mrst_fail", s_fail, 64'd0);
        check("mrst_halted", 64'(s_halted), 64'd0);
        check("mrst_done", 64'(s_done), 64'd0);
        rst_a = 1'b0;
        sb_reset();
        tick(); tick(); tick();
        check("mrst_no_issue", 64'(issue_k), 64'd0);
        repeat (10) drive_inst(1'b1, 32'h0);
        inst_valid = 1'b0;
        wait_done(300);
        check("a3_pass", s_pass, 64'd100);
        check("a3_fail", s_fail, 64'd0);
        check("a3_issues", 64'(issue_k), 64'd100);

        // ---------------- B: cumulative halt with address wrap ----------------
        rst_a = 1'b1;
        active = 1; nwords = NB; base = 32'hF8; amask = 32'hFF;
        sb_reset();
        exp_mem[2] = exp_mem[2] ^ 32'h0000_0010;
        tick();
        check("b_rst_rd_en", 64'(s_rd_en), 64'd0);
        check("b_rst_halted", 64'(s_halted), 64'd0);
        check("b_rst_done", 64'(s_done), 64'd0);
        rst_b = 1'b0;
        repeat (9) drive_inst(1'b1, 32'h0);
        drive_inst(1'b1, 32'h2002_0005);
        check("b_cum_not_halted", 64'(s_halted), 64'd0);
        drive_inst(1'b1, 32'h0);
        check("b_cum_halted", 64'(s_halted), 64'd1);
        check("b_cum_rd_en_0", 64'(s_rd_en), 64'd0);
        inst_valid = 1'b0;
        wait_done(50);
        check("b1_done_latency", 64'(cyc - first_rd_cyc), 64'(NB + 2));
        check("b1_pass", s_pass, 64'd3);
        check("b1_fail", s_fail, 64'd1);
        check("b1_first", s_first, 64'd2);
        check("b1_issues", 64'(issue_k), 64'd4);
        exp_mem[2] = dut_mem[2];

        // ---------------- B: force_check ----------------
        rst_b = 1'b1; tick(); rst_b = 1'b0;
        sb_reset();
        tick(); tick();
        force_b = 1'b1;
        tick();
        force_b = 1'b0;
        check("force_halted", 64'(s_halted), 64'd0);
        check("force_rd_en_0", 64'(s_rd_en), 64'd0);
        tick();
        check("force_first_rd_en", 64'(s_rd_en), 64'd1);
        force_b = 1'b1;
        tick();
        force_b = 1'b0;
        wait_done(50);
        check("b2_halted", 64'(s_halted), 64'd0);
        check("b2_pass", s_pass, 64'd4);
        check("b2_fail", s_fail, 64'd0);
        check("b2_issues", 64'(issue_k), 64'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_result_checker.md
Name: mem_result_checker

Overview:
- Synthesizable end-of-program checker for the pipelined MIPS bench and the FPGA bring-up harness.
- Monitors the fetched instruction stream and detects program halt by counting NOP fetches.
- After halt, sweeps NUM_WORDS words of DUT data memory against an expected-result memory through two 1-cycle-latency read ports.
- Reports pass and fail counts, the first failing index, and a per-word compare stream for logging.

Parameters:
- WORD_WIDTH, 32, data word width in bits.
- ADDR_WIDTH, 32, byte-address width of both read ports.
- NUM_WORDS, 100, number of words compared; legal range is 1 or greater.
- BASE_ADDR, 0, byte address of word 0; word i is at BASE_ADDR + 4*i.
- HALT_COUNT, 10, number of NOP fetches that declares halt; legal range is 1 or greater.
- NOP_WORD, 32'h0, instruction encoding treated as NOP.
- HALT_MODE, 1, halt counting mode: 1 = consecutive NOPs, 0 = cumulative NOPs (legacy bench behaviour).
- CW, $clog2(NUM_WORDS+1), width of the count outputs (derived, not overridden).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- inst  in  WORD_WIDTH  instruction currently presented by instruction memory.
- inst_valid  in  1  inst is sampled only when this is high.
- force_check  in  1  single-cycle pulse; starts the sweep immediately, skipping halt detection.
- rd_en  out  1  read strobe, shared by both memories.
- rd_addr  out  ADDR_WIDTH  byte address, shared by both memories.
- dut_rdata  in  WORD_WIDTH  DUT memory data, valid 1 cycle after rd_en.
- exp_rdata  in  WORD_WIDTH  expected memory data, valid 1 cycle after rd_en.
- cmp_valid  out  1  per-word compare result is valid this cycle.
- cmp_idx  out  CW  index of the word being reported.
- cmp_match  out  1  1 when dut_rdata equals exp_rdata.
- pass_count  out  CW  number of matching words.
- fail_count  out  CW  number of mismatching words.
- first_fail_idx  out  CW  lowest failing index; holds 0 if no word fails.
- any_fail  out  1  at least one word has failed.
- halted  out  1  halt was detected (not set by force_check).
- done  out  1  sweep complete; sticky until rst.

Behaviour:
- Reset (rst high at a clock edge):
  - All outputs go to 0 and the FSM goes to WATCH.
  - Halt counter goes to 0.
  - Reset asserted mid-sweep aborts the sweep. No further rd_en is issued, and a read still in flight is discarded.
- FSM states: WATCH, SWEEP, DRAIN, DONE.
- WATCH:
  - On each inst_valid cycle where inst == NOP_WORD, the halt counter increments (saturating at HALT_COUNT).
  - A valid non-NOP clears the counter only when HALT_MODE = 1; it has no effect when HALT_MODE = 0.
  - When the counter reaches HALT_COUNT, set halted and go to SWEEP on the next edge.
  - force_check goes to SWEEP on the next edge; halted stays 0.
  - If both conditions occur in the same cycle, go to SWEEP and set halted.
- SWEEP:
  - rd_en is high for exactly NUM_WORDS consecutive cycles.
  - Issue k (k = 0 to NUM_WORDS-1) drives rd_addr = BASE_ADDR + 4*k, computed modulo 2^ADDR_WIDTH (wraps with no error).
  - After the last issue, go to DRAIN.
- Compare pipeline:
  - Read data sampled in the cycle after issue k produces registered outputs cmp_valid = 1, cmp_idx = k, cmp_match one cycle later.
  - Total latency from issue k to the cmp_valid for k is 2 cycles.
  - Counters update on the same edge that registers the compare.
  - first_fail_idx and any_fail are captured only on the first mismatch.
  - pass_count + fail_count equals the number of reported words at all times.
- DRAIN: wait until the compare for word NUM_WORDS-1 is registered, then go to DONE.
- DONE:
  - done = 1; rd_en = 0; cmp_valid = 0.
  - All counts are held.
  - Further inst or force_check activity is ignored until rst.
- inst_valid low during WATCH: no counter change.
- force_check during SWEEP, DRAIN or DONE: ignored.
- Comparison is bitwise over the full WORD_WIDTH. Any X/Z on read data counts as a mismatch in simulation.

Test Plan:
- Consecutive halt, all match: HALT_MODE=1, HALT_COUNT=10, NUM_WORDS=100, both memories identical; feed 5 non-NOPs then 10 NOPs -> halted=1, first rd_en 1 cycle later, done asserted 102 cycles after first rd_en, pass_count=100, fail_count=0, any_fail=0.
- Interrupted NOP run: HALT_MODE=1; feed 9 NOPs, 1 non-NOP, 9 NOPs -> no sweep, halted=0. Repeat with HALT_MODE=0 -> halted on the 10th cumulative NOP.
- Mismatches: exp differs at words 7 and 42 -> fail_count=2, pass_count=98, first_fail_idx=7; cmp_match=0 exactly when cmp_idx is 7 and 42.
- force_check: pulse at cycle 3 with no NOPs, NUM_WORDS=4, BASE_ADDR=0x100 -> rd_addr sequence 0x100, 0x104, 0x108, 0x10C; halted=0; done=1.
- Address wrap: ADDR_WIDTH=8, BASE_ADDR=0xF8, NUM_WORDS=4 -> rd_addr sequence 0xF8, 0xFC, 0x00, 0x04.
- Mid-sweep reset: assert rst at the 50th rd_en -> next cycle rd_en=0, all counts 0, state WATCH. A fresh halt then yields a full, correct 100-word sweep.
